// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator and its receive-side checker.
// The generator and the checker both take lfsr_next from here, so they cannot disagree on the polynomial.
package lfsr_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SEED    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } chk_state_t;

    // Shift left; the new bit 0 is the XOR of bits 15, 13, 12 and 10.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// Receive-side PRBS checker: self-synchronises to an LFSR word stream, then counts mismatching words.
// Once locked, the checker runs as a flywheel: bad words never reseed the prediction.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [LFSR_W-1:0]    in_data,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 zero_seen
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end else begin
            return cnt + ERR_CNT_W'(1);
        end
    endfunction

    chk_state_t           state_q, state_d;
    logic [LFSR_W-1:0]    expected_q, expected_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 zero_seen_q, zero_seen_d;

    logic                 word_match_s;
    logic                 word_zero_s;
    logic [RUN_W-1:0]     run_inc_s;
    logic [MISS_W-1:0]    miss_inc_s;
    logic [ERR_CNT_W-1:0] err_base_s;
    logic                 zero_base_s;

    assign word_match_s = (in_data == expected_q);
    assign word_zero_s  = (in_data == {LFSR_W{1'b0}});
    assign run_inc_s    = run_q + RUN_W'(1);
    assign miss_inc_s   = miss_q + MISS_W'(1);
    // Clear acts first, so a counted error in the same cycle lands on a fresh zero.
    assign err_base_s   = clear ? {ERR_CNT_W{1'b0}} : err_count_q;
    assign zero_base_s  = clear ? 1'b0 : zero_seen_q;

    // Next-state, prediction and output computation for one accepted word.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        run_d       = run_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_base_s;
        zero_seen_d = zero_base_s;

        if (in_valid) begin
            case (state_q)
                SEED: begin
                    if (word_zero_s) begin
                        zero_seen_d = 1'b1;
                    end else begin
                        expected_d = lfsr_next(in_data);
                        run_d      = {RUN_W{1'b0}};
                        state_d    = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (word_match_s) begin
                        expected_d = lfsr_next(in_data);
                        run_d      = run_inc_s;
                        if (run_inc_s == RUN_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = {MISS_W{1'b0}};
                        end else begin
                            state_d  = ACQUIRE;
                        end
                    end else if (!word_zero_s) begin
                        expected_d = lfsr_next(in_data);
                        run_d      = {RUN_W{1'b0}};
                    end else begin
                        state_d     = SEED;
                        zero_seen_d = 1'b1;
                    end
                end
                LOCKED: begin
                    expected_d = lfsr_next(expected_q);
                    if (word_match_s) begin
                        miss_d = {MISS_W{1'b0}};
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = sat_inc(err_base_s);
                        miss_d      = miss_inc_s;
                        if (word_zero_s) begin
                            zero_seen_d = 1'b1;
                        end else begin
                            zero_seen_d = zero_base_s;
                        end
                        if (miss_inc_s == MISS_W'(LOSS_COUNT)) begin
                            state_d  = SEED;
                            locked_d = 1'b0;
                            run_d    = {RUN_W{1'b0}};
                        end else begin
                            state_d  = LOCKED;
                        end
                    end
                end
                default: begin
                    state_d  = SEED;
                    locked_d = 1'b0;
                    run_d    = {RUN_W{1'b0}};
                end
            endcase
        end else begin
            err_pulse_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q     <= SEED;
            expected_q  <= {LFSR_W{1'b0}};
            run_q       <= {RUN_W{1'b0}};
            miss_q      <= {MISS_W{1'b0}};
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= {ERR_CNT_W{1'b0}};
            zero_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            zero_seen_q <= zero_seen_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign zero_seen = zero_seen_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: a default instance plus a narrow-counter, long-flywheel instance.
module tb_lfsr_seq_checker;

    logic        clk;
    logic        nreset;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        zero_seen;

    logic        clear6;
    logic        in_valid6;
    logic [15:0] in_data6;
    logic        locked6;
    logic        err_pulse6;
    logic [3:0]  err_count6;
    logic        zero_seen6;

    int          tests;
    int          fails;
    logic [15:0] cur;

    lfsr_seq_checker dut (
        .clk(clk), .nReset(nreset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .zero_seen(zero_seen)
    );

    lfsr_seq_checker #(.LOCK_COUNT(4), .LOSS_COUNT(32), .ERR_CNT_W(4)) dut6 (
        .clk(clk), .nReset(nreset), .clear(clear6), .in_valid(in_valid6), .in_data(in_data6),
        .locked(locked6), .err_pulse(err_pulse6), .err_count(err_count6), .zero_seen(zero_seen6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: explicit tap bits 15, 13, 12, 10.
    function automatic logic [15:0] tb_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] w, input logic clr);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        clear    = clr;
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic send6(input logic [15:0] w, input logic clr);
        @(negedge clk);
        in_valid6 = 1'b1;
        in_data6  = w;
        clear6    = clr;
        @(negedge clk);
        in_valid6 = 1'b0;
        clear6    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        tests = 0; fails = 0;
        nreset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        clear6 = 1'b0; in_valid6 = 1'b0; in_data6 = 16'h0000;
        idle(3);
        nreset = 1'b1;

        // Reference sequence sanity against hand-computed words.
        chk("ref_1", {16'h0, tb_next(16'hACE1)}, 32'h0000_59C3);
        chk("ref_2", {16'h0, tb_next(16'h59C3)}, 32'h0000_B387);
        chk("ref_5", {16'h0, tb_next(16'h670F)}, 32'h0000_CE1E);

        chk("rst_locked", {31'h0, locked}, 32'h0);
        chk("rst_pulse", {31'h0, err_pulse}, 32'h0);
        chk("rst_count", {16'h0, err_count}, 32'h0);
        chk("rst_zero", {31'h0, zero_seen}, 32'h0);

        // 1: lock after seed plus four matches.
        send(16'hACE1, 1'b0);
        send(16'h59C3, 1'b0);
        send(16'hB387, 1'b0);
        send(16'h670F, 1'b0);
        chk("t1_not_yet", {31'h0, locked}, 32'h0);
        send(16'hCE1E, 1'b0);
        chk("t1_locked", {31'h0, locked}, 32'h1);
        chk("t1_count", {16'h0, err_count}, 32'h0);
        cur = 16'hCE1E;

        // 2: single bit error, then good word.
        cur = tb_next(cur);
        send(cur ^ 16'h0001, 1'b0);
        chk("t2_pulse", {31'h0, err_pulse}, 32'h1);
        chk("t2_count", {16'h0, err_count}, 32'h1);
        chk("t2_locked", {31'h0, locked}, 32'h1);
        idle(1);
        chk("t2_pulse_1cyc", {31'h0, err_pulse}, 32'h0);
        cur = tb_next(cur);
        send(cur, 1'b0);
        chk("t2_good_nopulse", {31'h0, err_pulse}, 32'h0);
        chk("t2_count_hold", {16'h0, err_count}, 32'h1);

        // 3: clear, then three consecutive bad words drop lock.
        pulse_clear();
        chk("t3_cleared", {16'h0, err_count}, 32'h0);
        chk("t3_clear_keeps_lock", {31'h0, locked}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cur = tb_next(cur);
            send(cur ^ 16'h0100, 1'b0);
            chk("t3_locked_during", {31'h0, locked}, (i < 2) ? 32'h1 : 32'h0);
        end
        chk("t3_count", {16'h0, err_count}, 32'h3);
        for (int i = 0; i < 5; i++) begin
            cur = tb_next(cur);
            send(cur, 1'b0);
            chk("t3_relock", {31'h0, locked}, (i == 4) ? 32'h1 : 32'h0);
        end
        chk("t3_acq_not_counted", {16'h0, err_count}, 32'h3);

        // 4: zero word in SEED, lock, clear; zero word while locked.
        do_reset();
        chk("t4_rst_locked", {31'h0, locked}, 32'h0);
        chk("t4_rst_count", {16'h0, err_count}, 32'h0);
        send(16'h0000, 1'b0);
        chk("t4_zero_seen", {31'h0, zero_seen}, 32'h1);
        cur = 16'hACE1;
        send(cur, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cur = tb_next(cur);
            send(cur, 1'b0);
        end
        chk("t4_stayed_seed", {31'h0, locked}, 32'h0);
        cur = tb_next(cur);
        send(cur, 1'b0);
        chk("t4_locked", {31'h0, locked}, 32'h1);
        pulse_clear();
        chk("t4_zero_cleared", {31'h0, zero_seen}, 32'h0);
        cur = tb_next(cur);
        send(16'h0000, 1'b0);
        chk("t4_zl_pulse", {31'h0, err_pulse}, 32'h1);
        chk("t4_zl_zero", {31'h0, zero_seen}, 32'h1);
        chk("t4_zl_count", {16'h0, err_count}, 32'h1);
        chk("t4_zl_locked", {31'h0, locked}, 32'h1);

        // 5: random gaps keep lock; reset discards sync.
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            cur = tb_next(cur);
            send(cur, 1'b0);
            idle(int'($urandom_range(0, 7)));
        end
        chk("t5_gap_locked", {31'h0, locked}, 32'h1);
        chk("t5_gap_count", {16'h0, err_count}, 32'h0);
        do_reset();
        chk("t5_rst_locked", {31'h0, locked}, 32'h0);
        chk("t5_rst_count", {16'h0, err_count}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cur = tb_next(cur);
            send(cur, 1'b0);
            chk("t5_fresh_seed", {31'h0, locked}, (i == 4) ? 32'h1 : 32'h0);
        end

        // Acquire reseed on a nonzero mismatch; errors not counted there.
        do_reset();
        send(16'hACE1, 1'b0);
        send(16'h59C3, 1'b0);
        cur = 16'h1234;
        send(cur, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cur = tb_next(cur);
            send(cur, 1'b0);
            chk("acq_reseed", {31'h0, locked}, (i == 3) ? 32'h1 : 32'h0);
        end
        chk("acq_no_count", {16'h0, err_count}, 32'h0);

        // 6: narrow counter saturates; clear with a bad word gives 1.
        cur = 16'hACE1;
        send6(cur, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cur = tb_next(cur);
            send6(cur, 1'b0);
        end
        chk("t6_locked", {31'h0, locked6}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            cur = tb_next(cur);
            send6(cur ^ 16'h8000, 1'b0);
            if (i == 14) chk("t6_at_15", {28'h0, err_count6}, 32'hF);
        end
        chk("t6_sat", {28'h0, err_count6}, 32'hF);
        chk("t6_still_locked", {31'h0, locked6}, 32'h1);
        cur = tb_next(cur);
        send6(cur ^ 16'h0010, 1'b1);
        chk("t6_clear_err", {28'h0, err_count6}, 32'h1);
        cur = tb_next(cur);
        send6(16'h0000, 1'b1);
        chk("t6_clear_zero", {31'h0, zero_seen6}, 32'h1);
        chk("t6_clear_err2", {28'h0, err_count6}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
